// File: rtl/led_pkg.sv
// Shared encodings for the LED pattern engine: display modes and FSM states.
package led_pkg;

    localparam logic [1:0] MODE_ROT   = 2'b00;
    localparam logic [1:0] MODE_BNC   = 2'b01;
    localparam logic [1:0] MODE_FILL  = 2'b10;
    localparam logic [1:0] MODE_BLINK = 2'b11;

    typedef enum logic [2:0] {
        ST_ROT    = 3'd0,
        ST_BNC_UP = 3'd1,
        ST_BNC_DN = 3'd2,
        ST_FILL   = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_BLINK  = 3'd5
    } state_t;

    // First state of a mode; bounce starts travelling in the requested direction.
    function automatic state_t entry_state(input logic [1:0] mode, input logic dir);
        state_t st;
        case (mode)
            MODE_ROT:  st = ST_ROT;
            MODE_BNC:  st = dir ? ST_BNC_UP : ST_BNC_DN;
            MODE_FILL: st = ST_FILL;
            default:   st = ST_BLINK;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/step_prescaler.sv
// Programmable step prescaler: emits a step every i_limit+1 enabled clocks.
module step_prescaler #(
    parameter int N_CNT = 27
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_enable,
    input  logic             i_clear,
    input  logic [N_CNT-1:0] i_limit,
    output logic             o_step
);

    logic [N_CNT-1:0] cnt;

    // Terminal compare uses >= so lowering i_limit below cnt steps immediately.
    assign o_step = i_enable && (cnt >= i_limit);

    // Counter: clear wins, wraps to zero on a step, freezes while disabled.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt <= '0;
        end else if (i_clear || o_step) begin
            cnt <= '0;
        end else if (i_enable) begin
            cnt <= cnt + N_CNT'(1);
        end
    end

endmodule

// File: rtl/led_pattern_engine.sv
// Multi-mode LED pattern generator: rotate, bounce, bar-fill and blink,
// advanced by an internal prescaler, with synchronous load and status pulses.
module led_pattern_engine
    import led_pkg::*;
#(
    parameter int N_LEDS = 8,
    parameter int N_CNT  = 27
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_enable,
    input  logic [1:0]        i_mode,
    input  logic              i_dir,
    input  logic [N_CNT-1:0]  i_limit,
    input  logic              i_load,
    input  logic [N_LEDS-1:0] i_pattern,
    output logic [N_LEDS-1:0] o_led,
    output logic              o_tick,
    output logic              o_wrap
);

    logic              step;
    state_t            state, eff_state, nxt_state;
    logic [1:0]        mode_q;
    logic              blink_ph, eff_ph, nxt_ph;
    logic [N_LEDS-1:0] nxt_led;
    logic              nxt_wrap;

    step_prescaler #(.N_CNT(N_CNT)) u_prescaler (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_enable  (i_enable),
        .i_clear   (i_load),
        .i_limit   (i_limit),
        .o_step    (step)
    );

    // Next pattern/state for a step; a mode change re-enters and steps at the same edge.
    always_comb begin
        eff_state = state;
        eff_ph    = blink_ph;
        if (i_mode != mode_q) begin
            eff_state = entry_state(i_mode, i_dir);
            eff_ph    = 1'b0;
        end
        nxt_led   = o_led;
        nxt_state = eff_state;
        nxt_wrap  = 1'b0;
        nxt_ph    = eff_ph;
        case (eff_state)
            ST_ROT: begin
                if (i_dir) begin
                    nxt_led  = {o_led[N_LEDS-2:0], o_led[N_LEDS-1]};
                    nxt_wrap = o_led[N_LEDS-1];
                end else begin
                    nxt_led  = {o_led[0], o_led[N_LEDS-1:1]};
                    nxt_wrap = o_led[0];
                end
            end
            ST_BNC_UP: begin
                if (o_led[N_LEDS-1]) begin
                    nxt_led   = {1'b0, o_led[N_LEDS-1:1]};
                    nxt_state = ST_BNC_DN;
                    nxt_wrap  = 1'b1;
                end else begin
                    nxt_led = {o_led[N_LEDS-2:0], 1'b0};
                end
            end
            ST_BNC_DN: begin
                if (o_led[0]) begin
                    nxt_led   = {o_led[N_LEDS-2:0], 1'b0};
                    nxt_state = ST_BNC_UP;
                    nxt_wrap  = 1'b1;
                end else begin
                    nxt_led = {1'b0, o_led[N_LEDS-1:1]};
                end
            end
            ST_FILL: begin
                nxt_led = i_dir ? {o_led[N_LEDS-2:0], 1'b1} : {1'b1, o_led[N_LEDS-1:1]};
                if (&nxt_led) begin
                    nxt_state = ST_DRAIN;
                    nxt_wrap  = 1'b1;
                end
            end
            ST_DRAIN: begin
                nxt_led = i_dir ? {o_led[N_LEDS-2:0], 1'b0} : {1'b0, o_led[N_LEDS-1:1]};
                if (nxt_led == '0) begin
                    nxt_state = ST_FILL;
                    nxt_wrap  = 1'b1;
                end
            end
            ST_BLINK: begin
                nxt_led  = ~o_led;
                nxt_wrap = eff_ph;
                nxt_ph   = ~eff_ph;
            end
            default: begin
                nxt_state = ST_ROT;
            end
        endcase
    end

    // State and output registers: reset > load > step > hold; pulses last one cycle.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_led    <= N_LEDS'(1);
            state    <= ST_ROT;
            mode_q   <= MODE_ROT;
            blink_ph <= 1'b0;
            o_tick   <= 1'b0;
            o_wrap   <= 1'b0;
        end else if (i_load) begin
            o_led    <= i_pattern;
            state    <= entry_state(i_mode, i_dir);
            mode_q   <= i_mode;
            blink_ph <= 1'b0;
            o_tick   <= 1'b0;
            o_wrap   <= 1'b0;
        end else if (step) begin
            o_led    <= nxt_led;
            state    <= nxt_state;
            mode_q   <= i_mode;
            blink_ph <= nxt_ph;
            o_tick   <= 1'b1;
            o_wrap   <= nxt_wrap;
        end else begin
            o_tick   <= 1'b0;
            o_wrap   <= 1'b0;
        end
    end

endmodule
